// File: rtl/twos_to_sign_mag_serial.sv
// Digit-serial two's-complement to sign/magnitude converter, LSB digit first.
// One word in flight at a time; valid/ready on both sides.
`timescale 1ns/1ps
module twos_to_sign_mag_serial #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_mag,
  output logic             out_sign,
  output logic             out_zero,
  output logic             out_min
);

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

  generate
    if (WIDTH % DIGIT != 0) begin : g_bad_digit
      $error("WIDTH must be a multiple of DIGIT");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] work_q;
  logic [WIDTH-1:0] work_d;
  logic [CNT_W-1:0] cnt_q;
  logic             carry_q;
  logic             carry_d;
  logic             neg_q;
  logic             zero_q;
  logic             min_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_mag_q;
  logic             out_sign_q;
  logic             out_zero_q;
  logic             out_min_q;

  logic [DIGIT:0]   digit_sum;
  logic [DIGIT-1:0] digit_out;

  // Negation digit: invert and add the carry rippled in from the lower digit.
  assign digit_sum = {1'b0, ~work_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_q};
  assign digit_out = neg_q ? digit_sum[DIGIT-1:0] : work_q[DIGIT-1:0];
  assign carry_d   = neg_q & digit_sum[DIGIT];

  // The working word shifts right; converted digits enter at the top so the
  // finished magnitude lands in place after N shifts.
  generate
    if (N == 1) begin : g_single
      assign work_d = digit_out;
    end else begin : g_shift
      assign work_d = {digit_out, work_q[WIDTH-1:DIGIT]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      work_q      <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      neg_q       <= 1'b0;
      zero_q      <= 1'b0;
      min_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_mag_q   <= '0;
      out_sign_q  <= 1'b0;
      out_zero_q  <= 1'b0;
      out_min_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          in_ready_q <= 1'b1;
          if (in_valid && in_ready_q) begin
            work_q     <= in_data;
            neg_q      <= in_signed & in_data[WIDTH-1];
            carry_q    <= in_signed & in_data[WIDTH-1];
            cnt_q      <= '0;
            zero_q     <= (in_data == '0);
            min_q      <= in_signed && (in_data == MOST_NEG);
            in_ready_q <= 1'b0;
            state_q    <= CONV;
          end
        end
        CONV: begin
          work_q  <= work_d;
          carry_q <= carry_d;
          cnt_q   <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST_CNT) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            out_mag_q   <= work_d;
            out_sign_q  <= neg_q;
            out_zero_q  <= zero_q;
            out_min_q   <= min_q;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q    <= IDLE;
          in_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_mag   = out_mag_q;
  assign out_sign  = out_sign_q;
  assign out_zero  = out_zero_q;
  assign out_min   = out_min_q;

endmodule

// File: tb/tb_twos_to_sign_mag_serial.sv
// Bench for twos_to_sign_mag_serial: directed table, handshake/reset corners,
// random words against an arithmetic abs() model, and a DIGIT=1/8/32 sweep.
`timescale 1ns/1ps
module tb_twos_to_sign_mag_serial;
  localparam int W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         sw_rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         in_signed;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_mag;
  logic         out_sign;
  logic         out_zero;
  logic         out_min;

  int n_cmp  = 0;
  int n_fail = 0;

  twos_to_sign_mag_serial #(.WIDTH(W), .DIGIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_signed(in_signed),
    .out_valid(out_valid), .out_ready(out_ready), .out_mag(out_mag),
    .out_sign(out_sign), .out_zero(out_zero), .out_min(out_min)
  );

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: interpret the word as an integer and take its absolute value.
  function automatic void ref_model(input logic [W-1:0] d, input logic s,
                                    output logic [W-1:0] mag, output logic sg,
                                    output logic z, output logic mn);
    longint v;
    v   = s ? longint'($signed(d)) : longint'({32'b0, d});
    sg  = (v < 0);
    z   = (v == 0);
    mn  = (v == -(longint'(1) <<< 31));
    mag = W'(sg ? -v : v);
  endfunction

  function automatic logic [W-1:0] pick_word();
    int sel;
    sel = $urandom_range(0, 9);
    case (sel)
      0: return 32'h0000_0000;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'hFFFF_0000;
      default: return $urandom;
    endcase
  endfunction

  task automatic run_word(input logic [W-1:0] d, input logic s, input int bp,
                          output logic [W-1:0] mag, output logic sg,
                          output logic z, output logic mn, output int lat);
    int guard;
    out_ready = (bp == 0);
    in_data   = d;
    in_signed = s;
    in_valid  = 1'b1;
    guard = 0;
    while (in_ready !== 1'b1 && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    check("accept_in_time", 32'(guard < 50), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
    end while (out_valid !== 1'b1 && lat < 100);
    mag = out_mag; sg = out_sign; z = out_zero; mn = out_min;
    for (int i = 0; i < bp; i++) begin
      @(posedge clk); #1;
      check("bp_valid_held", out_valid, 1'b1);
      check("bp_mag_stable", out_mag, mag);
      check("bp_in_ready_low", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("handshake_clears_valid", out_valid, 1'b0);
  endtask

  typedef struct {
    logic [W-1:0] data;
    logic         sgn;
    logic [W-1:0] mag;
    logic         sign;
    logic         zero;
    logic         min;
  } vec_t;

  vec_t vecs[11];

  // Parameter sweep: independent instances with their own reset.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : sweep
      localparam int DG = (gi == 0) ? 1 : (gi == 1) ? 8 : 32;
      logic         s_in_valid;
      logic         s_in_ready;
      logic [W-1:0] s_in_data;
      logic         s_in_signed;
      logic         s_out_valid;
      logic         s_out_ready;
      logic [W-1:0] s_out_mag;
      logic         s_out_sign;
      logic         s_out_zero;
      logic         s_out_min;
      bit           done = 1'b0;

      twos_to_sign_mag_serial #(.WIDTH(W), .DIGIT(DG)) dut_s (
        .clk(clk), .rst_n(sw_rst_n),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
        .in_signed(s_in_signed), .out_valid(s_out_valid), .out_ready(s_out_ready),
        .out_mag(s_out_mag), .out_sign(s_out_sign), .out_zero(s_out_zero),
        .out_min(s_out_min)
      );

      initial begin
        logic [W-1:0] d, emag;
        logic         s, es, ez, em;
        int           lat, guard;
        s_in_valid  = 1'b0;
        s_in_data   = '0;
        s_in_signed = 1'b0;
        s_out_ready = 1'b0;
        @(posedge sw_rst_n);
        @(posedge clk); #1;
        for (int k = 0; k < 1000; k++) begin
          d = pick_word();
          s = 1'($urandom_range(0, 1));
          ref_model(d, s, emag, es, ez, em);
          s_in_data = d; s_in_signed = s; s_in_valid = 1'b1;
          guard = 0;
          while (s_in_ready !== 1'b1 && guard < 50) begin
            @(posedge clk); #1; guard++;
          end
          if (guard >= 50) check($sformatf("d%0d_accept_in_time", DG), 32'd0, 32'd1);
          @(posedge clk); #1;
          s_in_valid = 1'b0;
          lat = 0;
          do begin
            @(posedge clk); #1; lat++;
          end while (s_out_valid !== 1'b1 && lat < 100);
          check($sformatf("d%0d_latency", DG), 32'(lat), 32'(W / DG));
          check($sformatf("d%0d_mag[%08h,%0b]", DG, d, s), s_out_mag, emag);
          check($sformatf("d%0d_sign", DG), s_out_sign, es);
          check($sformatf("d%0d_zero", DG), s_out_zero, ez);
          check($sformatf("d%0d_min", DG), s_out_min, em);
          s_out_ready = 1'b1;
          @(posedge clk); #1;
          s_out_ready = 1'b0;
        end
        done = 1'b1;
      end
    end
  endgenerate

  initial begin
    logic [W-1:0] mag, emag;
    logic         sg, z, mn, es, ez, em, s;
    logic [W-1:0] d;
    int           lat, guard;

    vecs[0]  = '{32'hFFFF_FFFF, 1'b1, 32'h0000_0001, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{32'h8000_0000, 1'b1, 32'h8000_0000, 1'b1, 1'b0, 1'b1};
    vecs[2]  = '{32'h8000_0000, 1'b0, 32'h8000_0000, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{32'h0000_0000, 1'b1, 32'h0000_0000, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{32'hFFFF_0000, 1'b1, 32'h0001_0000, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{32'hFFFF_FFF6, 1'b1, 32'h0000_000A, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{32'h0000_0005, 1'b1, 32'h0000_0005, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{32'h7FFF_FFFF, 1'b1, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{32'h8000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b0};

    rst_n = 1'b0; sw_rst_n = 1'b0;
    in_valid = 1'b0; in_data = '0; in_signed = 1'b0; out_ready = 1'b0;
    #1;
    check("reset_in_ready", in_ready, 1'b0);
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_out_mag", out_mag, 32'h0);
    check("reset_out_flags", {out_sign, out_zero, out_min}, 3'b000);
    #21;
    rst_n = 1'b1; sw_rst_n = 1'b1;
    @(posedge clk); #1;
    check("release_in_ready", in_ready, 1'b1);

    for (int i = 0; i < 11; i++) begin
      run_word(vecs[i].data, vecs[i].sgn, 0, mag, sg, z, mn, lat);
      $display("vec %0d: data=%08h signed=%0b -> mag=%08h sign=%0b zero=%0b min=%0b lat=%0d",
               i, vecs[i].data, vecs[i].sgn, mag, sg, z, mn, lat);
      check($sformatf("vec%0d_mag", i), mag, vecs[i].mag);
      check($sformatf("vec%0d_sign", i), sg, vecs[i].sign);
      check($sformatf("vec%0d_zero", i), z, vecs[i].zero);
      check($sformatf("vec%0d_min", i), mn, vecs[i].min);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'd8);
    end

    // Backpressure: second word presented throughout, must wait for IDLE.
    out_ready = 1'b0;
    in_data = 32'hFFFF_FFF0; in_signed = 1'b1; in_valid = 1'b1;
    guard = 0;
    while (in_ready !== 1'b1 && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    @(posedge clk); #1;
    in_data = 32'h0000_1234; in_signed = 1'b0;
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
    end while (out_valid !== 1'b1 && lat < 100);
    check("bp_first_latency", 32'(lat), 32'd8);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_hold_valid", out_valid, 1'b1);
      check("bp_hold_mag", out_mag, 32'h0000_0010);
      check("bp_hold_sign", out_sign, 1'b1);
      check("bp_hold_in_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_release_valid", out_valid, 1'b0);
    check("bp_release_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    check("bp_second_accepted", in_ready, 1'b0);
    in_valid = 1'b0;
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
    end while (out_valid !== 1'b1 && lat < 100);
    check("bp_second_latency", 32'(lat), 32'd8);
    check("bp_second_mag", out_mag, 32'h0000_1234);
    check("bp_second_sign", out_sign, 1'b0);
    $display("bp: first=fffffff0 held 5 cycles, second=00001234 -> mag=%08h lat=%0d", out_mag, lat);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Asynchronous abort in the middle of a conversion.
    in_data = 32'hFFFF_FFF1; in_signed = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", out_valid, 1'b0);
    check("abort_out_mag", out_mag, 32'h0);
    check("abort_in_ready", in_ready, 1'b0);
    check("abort_flags", {out_sign, out_zero, out_min}, 3'b000);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check("abort_held_valid", out_valid, 1'b0);
    end
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("abort_release_in_ready", in_ready, 1'b1);
    run_word(32'hFFFF_FFF6, 1'b1, 0, mag, sg, z, mn, lat);
    $display("after abort: data=fffffff6 -> mag=%08h sign=%0b lat=%0d", mag, sg, lat);
    check("abort_fresh_mag", mag, 32'd10);
    check("abort_fresh_sign", sg, 1'b1);
    check("abort_fresh_latency", 32'(lat), 32'd8);

    // Random words with random backpressure.
    for (int k = 0; k < 200; k++) begin
      d = pick_word();
      s = 1'($urandom_range(0, 1));
      ref_model(d, s, emag, es, ez, em);
      run_word(d, s, $urandom_range(0, 3), mag, sg, z, mn, lat);
      $display("rand %0d: data=%08h signed=%0b -> mag=%08h sign=%0b zero=%0b min=%0b lat=%0d",
               k, d, s, mag, sg, z, mn, lat);
      check("rand_mag", mag, emag);
      check("rand_sign", sg, es);
      check("rand_zero", z, ez);
      check("rand_min", mn, em);
      check("rand_latency", 32'(lat), 32'd8);
    end

    guard = 0;
    while (!(sweep[0].done && sweep[1].done && sweep[2].done) && guard < 60000) begin
      @(posedge clk); guard++;
    end
    check("sweep_completed", 32'(guard < 60000), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
